// File: rtl/nes_vga_scaler_pkg.sv
// Shared geometry, widths and defaults for the NES-to-VGA scaler.
package nes_vga_scaler_pkg;

  localparam int RGB_W = 12;
  localparam int PIX_W = 6;

  localparam int H_OFFSET_DEF = 64;
  localparam int V_OFFSET_DEF = 0;
  localparam int NES_W_DEF    = 256;
  localparam int NES_H_DEF    = 240;
  localparam int WIN_W_DEF    = 2 * NES_W_DEF;
  localparam int WIN_H_DEF    = 2 * NES_H_DEF;

  localparam logic [RGB_W-1:0] BORDER_RGB_DEF = 12'h000;

  // Exclusive end coordinate of a 2x-scaled window starting at offset.
  function automatic int win_end(input int offset, input int span);
    return offset + 2 * span;
  endfunction

endpackage

// File: rtl/nes_vga_scaler_palette.sv
// NES 2C02 palette: 6-bit palette index to 12-bit {r,g,b}, combinational.
module nes_palette
  import nes_vga_scaler_pkg::*;
(
  input  logic [PIX_W-1:0] index,
  output logic [RGB_W-1:0] color
);

  // Fixed lookup table, one entry per palette index.
  always_comb begin
    color = 12'h000;
    case (index)
      6'h00: color = 12'h777; 6'h01: color = 12'h00F; 6'h02: color = 12'h00B; 6'h03: color = 12'h42B;
      6'h04: color = 12'h908; 6'h05: color = 12'hA02; 6'h06: color = 12'hA10; 6'h07: color = 12'h810;
      6'h08: color = 12'h530; 6'h09: color = 12'h070; 6'h0A: color = 12'h060; 6'h0B: color = 12'h050;
      6'h0C: color = 12'h045; 6'h0D: color = 12'h000; 6'h0E: color = 12'h000; 6'h0F: color = 12'h000;
      6'h10: color = 12'hBBB; 6'h11: color = 12'h07F; 6'h12: color = 12'h05F; 6'h13: color = 12'h64F;
      6'h14: color = 12'hD0C; 6'h15: color = 12'hE05; 6'h16: color = 12'hF30; 6'h17: color = 12'hE51;
      6'h18: color = 12'hA70; 6'h19: color = 12'h0B0; 6'h1A: color = 12'h0A0; 6'h1B: color = 12'h0A4;
      6'h1C: color = 12'h088; 6'h1D: color = 12'h000; 6'h1E: color = 12'h000; 6'h1F: color = 12'h000;
      6'h20: color = 12'hFFF; 6'h21: color = 12'h3BF; 6'h22: color = 12'h68F; 6'h23: color = 12'h97F;
      6'h24: color = 12'hF7F; 6'h25: color = 12'hF59; 6'h26: color = 12'hF75; 6'h27: color = 12'hFA4;
      6'h28: color = 12'hFB0; 6'h29: color = 12'hBF1; 6'h2A: color = 12'h5D5; 6'h2B: color = 12'h5F9;
      6'h2C: color = 12'h0ED; 6'h2D: color = 12'h777; 6'h2E: color = 12'h000; 6'h2F: color = 12'h000;
      6'h30: color = 12'hFFF; 6'h31: color = 12'hAEF; 6'h32: color = 12'hBBF; 6'h33: color = 12'hDBF;
      6'h34: color = 12'hFBF; 6'h35: color = 12'hFAC; 6'h36: color = 12'hFDB; 6'h37: color = 12'hFEA;
      6'h38: color = 12'hFD7; 6'h39: color = 12'hDF7; 6'h3A: color = 12'hBFB; 6'h3B: color = 12'hBFD;
      6'h3C: color = 12'h0FF; 6'h3D: color = 12'hFDF; 6'h3E: color = 12'h000; 6'h3F: color = 12'h000;
      default: color = 12'h000;
    endcase
  end

endmodule

// File: rtl/nes_vga_scaler.sv
// NES-to-VGA 2x2 scaler: ping-pong line buffers, two-stage p_tick pipeline,
// palette lookup, sync delay matching and write-collision detection.
module nes_vga_scaler
  import nes_vga_scaler_pkg::*;
#(
  parameter int H_OFFSET = H_OFFSET_DEF,
  parameter int V_OFFSET = V_OFFSET_DEF,
  parameter int NES_W    = NES_W_DEF,
  parameter int NES_H    = NES_H_DEF,
  parameter logic [RGB_W-1:0] BORDER_RGB = BORDER_RGB_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ppu_wr,
  input  logic [7:0]       ppu_x,
  input  logic [7:0]       ppu_y,
  input  logic [PIX_W-1:0] ppu_color,
  input  logic             p_tick,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             video_on,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [RGB_W-1:0] rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             collision,
  output logic             overrun
);

  localparam int H_END = win_end(H_OFFSET, NES_W);
  localparam int V_END = win_end(V_OFFSET, NES_H);

  // Two 256-entry line buffers; even NES lines in bank 0, odd in bank 1.
  logic [PIX_W-1:0] mem0 [256];
  logic [PIX_W-1:0] mem1 [256];

  logic [9:0]       dx, dy;
  logic [7:0]       nes_x;
  logic             rd_bank, in_h, in_v, in_win, wr_ok, col_hit;

  logic [PIX_W-1:0] ram_q;
  logic             s1_in_win, s1_von, s1_hs, s1_vs;
  logic [RGB_W-1:0] pal_rgb;

  // Window decode and collision condition from the live raster position.
  always_comb begin
    dx      = pixel_x - 10'(H_OFFSET);
    dy      = pixel_y - 10'(V_OFFSET);
    nes_x   = 8'(dx >> 1);
    rd_bank = 1'(dy >> 1);
    in_h    = (int'(pixel_x) >= H_OFFSET) && (int'(pixel_x) < H_END);
    in_v    = (int'(pixel_y) >= V_OFFSET) && (int'(pixel_y) < V_END);
    in_win  = video_on && in_h && in_v;
    wr_ok   = ppu_wr && (int'(ppu_y) < NES_H);
    col_hit = wr_ok && (ppu_y[0] == rd_bank) && in_v;
  end

  // PPU write port; out-of-range lines are dropped.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (ppu_y[0]) mem1[ppu_x] <= ppu_color;
      else          mem0[ppu_x] <= ppu_color;
    end
  end

  // Synchronous read-first read port; this register is the stage-1 data.
  always_ff @(posedge clk) begin
    if (p_tick) ram_q <= rd_bank ? mem1[nes_x] : mem0[nes_x];
  end

  // Stage 1: window flag, blanking and syncs travelling with the read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_in_win <= 1'b0;
      s1_von    <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
    end else if (p_tick) begin
      s1_in_win <= in_win;
      s1_von    <= video_on;
      s1_hs     <= hsync_in;
      s1_vs     <= vsync_in;
    end
  end

  nes_palette u_palette (
    .index (ram_q),
    .color (pal_rgb)
  );

  // Stage 2: colour select and aligned sync outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb   <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else if (p_tick) begin
      hsync <= s1_hs;
      vsync <= s1_vs;
      if (!s1_von)         rgb <= '0;
      else if (!s1_in_win) rgb <= BORDER_RGB;
      else                 rgb <= pal_rgb;
    end
  end

  // Collision pulse and sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      collision <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      collision <= col_hit;
      overrun   <= overrun | col_hit;
    end
  end

endmodule

// File: tb/tb_nes_vga_scaler.sv
// Randomized bench for nes_vga_scaler with a frame-level reference model.
module tb_nes_vga_scaler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ppu_wr = 1'b0;
  logic [7:0]  ppu_x = '0;
  logic [7:0]  ppu_y = '0;
  logic [5:0]  ppu_color = '0;
  logic        p_tick = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        video_on = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [11:0] rgb;
  logic        hsync, vsync, collision, overrun;

  localparam logic [11:0] BORDER = 12'h000;

  logic [11:0] pal [64] = '{
    12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
    12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
    12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hF30, 12'hE51,
    12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h3BF, 12'h68F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
    12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h777, 12'h000, 12'h000,
    12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
    12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'hFDF, 12'h000, 12'h000
  };

  logic [5:0]  shadow [2][256];
  logic [13:0] exp_q[$];
  logic [13:0] last_out;
  logic        exp_ovr;
  int          checks = 0;
  int          errors = 0;

  nes_vga_scaler dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ppu_wr    (ppu_wr),
    .ppu_x     (ppu_x),
    .ppu_y     (ppu_y),
    .ppu_color (ppu_color),
    .p_tick    (p_tick),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .video_on  (video_on),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .rgb       (rgb),
    .hsync     (hsync),
    .vsync     (vsync),
    .collision (collision),
    .overrun   (overrun)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {rgb, hsync, vsync} for the raster inputs currently applied.
  function automatic logic [13:0] model();
    int px, py;
    logic [11:0] c;
    px = int'(pixel_x);
    py = int'(pixel_y);
    if (!video_on) c = 12'h000;
    else if (px >= 64 && px < 64 + 512 && py < 480) c = pal[shadow[(py / 2) % 2][(px - 64) / 2]];
    else c = BORDER;
    return {c, hsync_in, vsync_in};
  endfunction

  // 640x480 raster: 800 columns, 525 rows, sync pulses at standard positions.
  task automatic set_raster(input int px, input int py);
    pixel_x  = 10'(px);
    pixel_y  = 10'(py);
    video_on = (px < 640) && (py < 480);
    hsync_in = (px >= 656) && (px < 752);
    vsync_in = (py >= 490) && (py < 492);
  endtask

  // One clock with optional p_tick; checks collision, overrun and video outputs.
  task automatic step(input bit tk);
    logic exp_col;
    p_tick  = tk;
    exp_col = ppu_wr && (ppu_y < 240) && (ppu_y % 2 == (pixel_y / 2) % 2) && (pixel_y < 480);
    if (tk) exp_q.push_back(model());
    @(posedge clk);
    #1;
    if (ppu_wr && ppu_y < 240) shadow[ppu_y % 2][ppu_x] = ppu_color;
    exp_ovr = exp_ovr | exp_col;
    check("collision", collision, exp_col);
    check("overrun", overrun, exp_ovr);
    if (exp_q.size() == 2) begin
      last_out = exp_q.pop_front();
      check("pixel", {rgb, hsync, vsync}, last_out);
    end else begin
      check("hold", {rgb, hsync, vsync}, last_out);
    end
    ppu_wr = 1'b0;
    p_tick = 1'b0;
  endtask

  task automatic write_step(input int x, input int y, input int c, input bit tk);
    ppu_wr    = 1'b1;
    ppu_x     = 8'(x);
    ppu_y     = 8'(y);
    ppu_color = 6'(c);
    step(tk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"}, rgb, 12'h000);
    check({tag, "_sync"}, {hsync, vsync}, 2'b00);
    check({tag, "_col"}, collision, 1'b0);
    check({tag, "_ovr"}, overrun, 1'b0);
  endtask

  // Restart the expected pipeline: only reset values are in flight.
  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(14'h0);
    last_out = 14'h0;
    exp_ovr  = 1'b0;
  endtask

  // Sweep one raster row, optional random PPU writes and idle clocks.
  task automatic sweep_row(input int py, input int ncols, input bit writes);
    for (int px = 0; px < ncols; px++) begin
      set_raster(px, py);
      if (writes && $urandom_range(0, 7) == 0) begin
        ppu_wr    = 1'b1;
        ppu_x     = 8'($urandom_range(0, 255));
        ppu_y     = 8'($urandom_range(0, 255));
        ppu_color = 6'($urandom_range(0, 63));
      end
      step(1'b1);
      if ($urandom_range(0, 3) == 0) step(1'b0);
    end
  endtask

  initial begin
    exp_ovr  = 1'b0;
    last_out = '0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      ppu_wr = 1'($urandom); ppu_x = 8'($urandom); ppu_y = 8'($urandom);
      ppu_color = 6'($urandom); p_tick = 1'($urandom);
      pixel_x = 10'($urandom); pixel_y = 10'($urandom);
      video_on = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      @(posedge clk);
      #1;
      check_reset_outputs("reset");
    end
    ppu_wr = 1'b0;
    p_tick = 1'b0;
    set_raster(0, 500);
    release_reset();

    // Fill both banks from outside the vertical window (no collisions).
    for (int x = 0; x < 256; x++) write_step(x, 0, x % 64, 1'b0);
    for (int x = 0; x < 256; x++) write_step(x, 1, $urandom_range(0, 63), 1'b0);

    // Scaling rows 0/1 (bank 0) with no concurrent writes, then rows 2/3 with writes.
    sweep_row(0, 800, 1'b0);
    sweep_row(1, 800, 1'b0);
    sweep_row(2, 800, 1'b1);
    sweep_row(3, 800, 1'b1);

    // Directed collision cases on row 2 (bank 1).
    set_raster(100, 2);
    write_step(5, 3, 6'h21, 1'b0);
    check("col_y3", collision, 1'b1);
    check("ovr_y3", overrun, 1'b1);
    step(1'b0);
    check("col_gone", collision, 1'b0);
    write_step(6, 4, 6'h22, 1'b0);
    check("col_y4", collision, 1'b0);
    write_step(5, 241, 6'h3F, 1'b0);
    check("col_y241", collision, 1'b0);
    sweep_row(2, 800, 1'b0);

    // Random raster positions, ticks and writes.
    for (int i = 0; i < 600; i++) begin
      set_raster($urandom_range(0, 799), $urandom_range(0, 524));
      if ($urandom_range(0, 3) == 0) begin
        ppu_wr    = 1'b1;
        ppu_x     = 8'($urandom_range(0, 255));
        ppu_y     = 8'($urandom_range(0, 255));
        ppu_color = 6'($urandom_range(0, 63));
      end
      step(1'($urandom_range(0, 1)));
    end

    // Mid-frame asynchronous reset during row 100.
    set_raster(100, 2);
    write_step(7, 1, 6'h10, 1'b0);
    sweep_row(100, 300, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    release_reset();
    sweep_row(100, 800, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_vga_scaler.md
Name: nes_vga_scaler

Overview:
- Sits directly downstream of video_sync and consumes its pixel_x, pixel_y, video_on, p_tick, hsync and vsync.
- Takes NES PPU pixels (256x240, 6-bit palette indices) from a ping-pong pair of line buffers.
- Upscales each pixel 2x2 into a 512x480 window inside the 640x480 raster and outputs 12-bit RGB with sync delayed to match.
- Fills the area outside the window with a border colour.

Parameters:
- H_OFFSET, 64, first VGA column of the NES window (window spans H_OFFSET to H_OFFSET+511).
- V_OFFSET, 0, first VGA row of the NES window (window spans V_OFFSET to V_OFFSET+479).
- NES_W, 256, NES pixels per line.
- NES_H, 240, NES lines per frame.
- BORDER_RGB, 12'h000, colour shown where video_on=1 outside the window.

Ports:
- clk  in  1  system clock, shared with video_sync.
- reset_n  in  1  asynchronous, active-low reset.
- ppu_wr  in  1  write strobe for one PPU pixel, one clk per pixel.
- ppu_x  in  8  NES column, 0..255.
- ppu_y  in  8  NES line, 0..239.
- ppu_color  in  6  NES palette index.
- p_tick  in  1  pixel enable from video_sync.
- pixel_x  in  10  VGA column from video_sync.
- pixel_y  in  10  VGA row from video_sync.
- video_on  in  1  display-area flag from video_sync.
- hsync_in  in  1  hsync from video_sync.
- vsync_in  in  1  vsync from video_sync.
- rgb  out  12  4:4:4 colour output {r,g,b}.
- hsync  out  1  hsync delayed to align with rgb.
- vsync  out  1  vsync delayed to align with rgb.
- collision  out  1  one-clk pulse when a PPU write hits the bank currently being displayed.
- overrun  out  1  sticky collision flag, cleared only by reset.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - rgb=0, hsync=0, vsync=0, collision=0, overrun=0.
  - All pipeline valid/video_on stages cleared.
  - Line-buffer RAM contents are not reset.
- Line buffers:
  - Two banks of 256x6 RAM, synchronous read, read-first.
  - Write: on ppu_wr with ppu_y<NES_H, write ppu_color into bank ppu_y[0] at address ppu_x.
  - Writes with ppu_y>=NES_H are ignored: no write and no collision.
- Window decode, evaluated on pixel_x/pixel_y when p_tick=1:
  - in_win = video_on and H_OFFSET<=pixel_x<H_OFFSET+2*NES_W and V_OFFSET<=pixel_y<V_OFFSET+2*NES_H.
  - nes_x = (pixel_x-H_OFFSET)>>1, truncated to 8 bits.
  - nes_line = (pixel_y-V_OFFSET)>>1.
  - rd_bank = nes_line[0].
  - Each NES line is therefore shown on two consecutive VGA rows, and each NES pixel on two consecutive columns.
- Pipeline (advances only on clk cycles with p_tick=1; holds otherwise):
  - Stage 1: register RAM read address/bank, in_win, video_on, hsync_in, vsync_in.
  - Stage 2: palette lookup of the RAM data; register rgb, hsync, vsync.
  - Latency is exactly 2 p_ticks from a pixel_x value to its rgb.
  - hsync and vsync carry the same 2-tick delay, so raster alignment is preserved.
- Output colour, stage 2:
  - video_on=0 gives rgb=12'h000.
  - video_on=1 and in_win=0 gives BORDER_RGB.
  - Otherwise rgb=palette(ram_data).
- Collision:
  - Condition: ppu_wr, ppu_y<NES_H, ppu_y[0]==rd_bank, and the current VGA row is inside the vertical window, with rd_bank sampled combinationally.
  - On that condition, collision pulses high for the next clk and overrun sets.
  - The write still proceeds.
- Simultaneous write and read of the same address: the read returns the old data.
- Mid-line reset: outputs go to reset values immediately. After release, the first valid rgb appears 2 p_ticks after the first p_tick.

Decomposition:
- Shared package:
  - window geometry localparams derived from H_OFFSET/V_OFFSET/NES_W/NES_H;
  - the RGB width (12);
  - the palette index width (6).
- Sub-module nes_palette: 64-entry x 12-bit combinational ROM of the NES 2C02 palette, instantiated in stage 2.
- Line-buffer RAM is inferred inside the top module; no separate module.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> rgb=0, hsync=0, vsync=0, collision=0, overrun=0. Release reset -> outputs stay 0 until 2 p_ticks have elapsed.
- Scaling: write bank 0 line 0 with color=x[5:0], then sweep VGA row 0 -> at pixel_x 64 and 65, rgb=palette[0] two ticks later; at 66 and 67, palette[1]; at 575, palette[63]. Row 1 shows identical values.
- Border and blanking: pixel_x=10 with video_on=1 -> rgb=BORDER_RGB after 2 ticks. pixel_x=700 with video_on=0 -> rgb=12'h000.
- Sync alignment: hsync_in rises at the tick where pixel_x=656 -> hsync rises exactly 2 p_ticks later. With p_tick low for a clk, the outputs hold.
- Collision: VGA at row 2 (nes_line 1, bank 1) and PPU writes y=3 -> collision=1 for 1 clk, overrun=1. PPU writes y=4 -> no pulse. PPU writes y=241 -> ignored, no pulse, RAM unchanged.
- Mid-frame reset: assert reset_n=0 during row 100 -> rgb, hsync and vsync drop to 0 asynchronously and overrun clears. Release reset -> correct pixels resume within 2 ticks.
